// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz VGA timing constants and pixel types used by every display stage.
package vga_timing_pkg;

   typedef logic [15:0] rgb565_t;
   typedef logic [10:0] coord_t;

   localparam int unsigned VGA_H_SYNC  = 96;
   localparam int unsigned VGA_H_BACK  = 48;
   localparam int unsigned VGA_H_DISP  = 640;
   localparam int unsigned VGA_H_FRONT = 16;
   localparam int unsigned VGA_V_SYNC  = 2;
   localparam int unsigned VGA_V_BACK  = 33;
   localparam int unsigned VGA_V_DISP  = 480;
   localparam int unsigned VGA_V_FRONT = 10;

   localparam int unsigned VGA_H_TOTAL = VGA_H_SYNC + VGA_H_BACK + VGA_H_DISP + VGA_H_FRONT;
   localparam int unsigned VGA_V_TOTAL = VGA_V_SYNC + VGA_V_BACK + VGA_V_DISP + VGA_V_FRONT;
   localparam int unsigned VGA_H_START = VGA_H_SYNC + VGA_H_BACK;
   localparam int unsigned VGA_V_START = VGA_V_SYNC + VGA_V_BACK;

   localparam rgb565_t RGB565_BLACK = 16'h0000;

endpackage

// File: rtl/vga_axis_counter.sv
// One VGA timing axis: wrapping position counter with sync, active and
// request-window decodes. LEAD shifts the request window ahead of the active one.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned SYNC     = VGA_H_SYNC,
   parameter int unsigned BACK     = VGA_H_BACK,
   parameter int unsigned DISP     = VGA_H_DISP,
   parameter int unsigned FRONT    = VGA_H_FRONT,
   parameter int unsigned LEAD     = 0,
   parameter logic        SYNC_POL = 1'b0
)(
   input  logic        clk,
   input  logic        rstn,
   input  logic        en,
   output logic        wrap,
   output logic        sync,
   output logic        active,
   output logic        req,
   output logic [10:0] pos
);

   localparam coord_t TOTAL     = 11'(SYNC + BACK + DISP + FRONT);
   localparam coord_t SYNC_END  = 11'(SYNC);
   localparam coord_t START     = 11'(SYNC + BACK);
   localparam coord_t STOP      = 11'(SYNC + BACK + DISP);
   localparam coord_t REQ_START = 11'(SYNC + BACK - LEAD);
   localparam coord_t REQ_STOP  = 11'(SYNC + BACK + DISP - LEAD);

   coord_t cnt;
   logic   last;

   always_ff @(posedge clk) begin
      if (!rstn)
         cnt <= '0;
      else if (en)
         cnt <= last ? '0 : cnt + 11'd1;
   end

   // pos is forced to zero outside the request window so the subtraction never shows underflow
   always_comb begin
      last   = (cnt == TOTAL - 11'd1);
      wrap   = en & last;
      sync   = (cnt < SYNC_END) ? SYNC_POL : ~SYNC_POL;
      active = (cnt >= START) && (cnt < STOP);
      req    = (cnt >= REQ_START) && (cnt < REQ_STOP);
      pos    = req ? cnt - REQ_START : '0;
   end

endmodule

// File: rtl/vga_timing_driver.sv
// VGA timing generator: sync/blank decode, one-clock-early pixel coordinate
// requests, blanked RGB565 pass-through and a per-frame tick.
module vga_timing_driver
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_SYNC   = VGA_H_SYNC,
   parameter int unsigned H_BACK   = VGA_H_BACK,
   parameter int unsigned H_DISP   = VGA_H_DISP,
   parameter int unsigned H_FRONT  = VGA_H_FRONT,
   parameter int unsigned V_SYNC   = VGA_V_SYNC,
   parameter int unsigned V_BACK   = VGA_V_BACK,
   parameter int unsigned V_DISP   = VGA_V_DISP,
   parameter int unsigned V_FRONT  = VGA_V_FRONT,
   parameter logic        SYNC_POL = 1'b0
)(
   input  logic        clk,
   input  logic        rstn,
   input  logic [15:0] pixel_data,
   output logic [10:0] pixel_xpos,
   output logic [10:0] pixel_ypos,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_en,
   output logic [15:0] vga_rgb,
   output logic        frame_tick
);

   logic   h_wrap, h_sync, h_active, h_req;
   logic   v_wrap, v_sync, v_active, v_req;
   coord_t h_pos, v_pos;
   logic   data_req;

   // Horizontal requests lead the display by one clock to absorb the generator's register stage
   vga_axis_counter #(
      .SYNC(H_SYNC), .BACK(H_BACK), .DISP(H_DISP), .FRONT(H_FRONT),
      .LEAD(1), .SYNC_POL(SYNC_POL)
   ) u_h (
      .clk(clk), .rstn(rstn), .en(1'b1),
      .wrap(h_wrap), .sync(h_sync), .active(h_active), .req(h_req), .pos(h_pos)
   );

   vga_axis_counter #(
      .SYNC(V_SYNC), .BACK(V_BACK), .DISP(V_DISP), .FRONT(V_FRONT),
      .LEAD(0), .SYNC_POL(SYNC_POL)
   ) u_v (
      .clk(clk), .rstn(rstn), .en(h_wrap),
      .wrap(v_wrap), .sync(v_sync), .active(v_active), .req(v_req), .pos(v_pos)
   );

   always_comb begin
      data_req   = h_req & v_req;
      pixel_xpos = data_req ? h_pos : '0;
      pixel_ypos = data_req ? v_pos : '0;
      vga_hs     = h_sync;
      vga_vs     = v_sync;
      vga_en     = h_active & v_active;
      vga_rgb    = vga_en ? pixel_data : RGB565_BLACK;
      frame_tick = v_wrap;
   end

endmodule

// File: tb/tb_vga_timing_driver.sv
// Directed bench for vga_timing_driver: default, inverted-sync and shrunken-timing builds.
module tb_vga_timing_driver;

   logic        clk = 1'b0;
   logic        rstn;
   logic        use_gen;
   logic [15:0] force_val;
   logic [15:0] gen_data = '0;
   logic [15:0] pixel_data;

   logic [10:0] xpos, ypos, xpos_p, ypos_p, xpos_s, ypos_s;
   logic        hs, vs, en, ft, hs_p, vs_p, en_p, ft_p, hs_s, vs_s, en_s, ft_s;
   logic [15:0] rgb, rgb_p, rgb_s;

   int pass_cnt = 0;
   int total_cnt = 0;
   int t = 0;
   int ft_hits = 0;

   localparam int T0 = 35 * 800;

   always #5 clk = ~clk;

   // Behaves like a downstream generator: registers a colour equal to the requested column
   always @(posedge clk) gen_data <= {5'd0, xpos};
   assign pixel_data = use_gen ? gen_data : force_val;

   vga_timing_driver dut (
      .clk(clk), .rstn(rstn), .pixel_data(pixel_data), .pixel_xpos(xpos), .pixel_ypos(ypos),
      .vga_hs(hs), .vga_vs(vs), .vga_en(en), .vga_rgb(rgb), .frame_tick(ft)
   );

   vga_timing_driver #(.SYNC_POL(1'b1)) dut_p (
      .clk(clk), .rstn(rstn), .pixel_data(pixel_data), .pixel_xpos(xpos_p), .pixel_ypos(ypos_p),
      .vga_hs(hs_p), .vga_vs(vs_p), .vga_en(en_p), .vga_rgb(rgb_p), .frame_tick(ft_p)
   );

   // Shrunken timing: 17 clocks per line, 10 lines per frame, 170 clocks per frame
   vga_timing_driver #(
      .H_SYNC(4), .H_BACK(3), .H_DISP(8), .H_FRONT(2),
      .V_SYNC(2), .V_BACK(3), .V_DISP(4), .V_FRONT(1)
   ) dut_s (
      .clk(clk), .rstn(rstn), .pixel_data(pixel_data), .pixel_xpos(xpos_s), .pixel_ypos(ypos_s),
      .vga_hs(hs_s), .vga_vs(vs_s), .vga_en(en_s), .vga_rgb(rgb_s), .frame_tick(ft_s)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      t++;
      if (ft === 1'b1) ft_hits++;
   endtask

   task automatic run_to(input int target);
      while (t < target) tick();
   endtask

   task automatic test_reset();
      rstn = 1'b0; use_gen = 1'b0; force_val = 16'hFFFF;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++; if ({hs, vs, en, ft} !== 4'b0000) $display("FAIL reset_flags: hs,vs,en,tick=%b want 0000", {hs, vs, en, ft}); else pass_cnt++;
      total_cnt++; if (rgb !== 16'h0000) $display("FAIL reset_rgb: got %h want 0000", rgb); else pass_cnt++;
      total_cnt++; if (xpos !== 11'd0 || ypos !== 11'd0) $display("FAIL reset_pos: got %0d,%0d want 0,0", xpos, ypos); else pass_cnt++;
      total_cnt++; if ({hs_p, vs_p} !== 2'b11) $display("FAIL reset_pol_sync: got %b want 11", {hs_p, vs_p}); else pass_cnt++;
      rstn = 1'b1;
      t = 0;
   endtask

   task automatic test_sync();
      int hs_low = 0;
      int pol_err = 0;
      while (t <= 1600) begin
         if (t < 800 && hs === 1'b0) hs_low++;
         if (hs_p !== ~hs || vs_p !== ~vs || en_p !== en) pol_err++;
         if (t == 95) begin
            total_cnt++; if (hs !== 1'b0 || hs_p !== 1'b1) $display("FAIL hs_95: hs=%b hs_p=%b want 0/1", hs, hs_p); else pass_cnt++;
         end
         if (t == 96) begin
            total_cnt++; if (hs !== 1'b1 || hs_p !== 1'b0) $display("FAIL hs_96: hs=%b hs_p=%b want 1/0", hs, hs_p); else pass_cnt++;
         end
         if (t == 800) begin
            total_cnt++; if (hs !== 1'b0) $display("FAIL hs_line1: got %b want 0", hs); else pass_cnt++;
         end
         if (t == 1599) begin
            total_cnt++; if (vs !== 1'b0 || vs_p !== 1'b1) $display("FAIL vs_1599: vs=%b vs_p=%b want 0/1", vs, vs_p); else pass_cnt++;
         end
         if (t == 1600) begin
            total_cnt++; if (vs !== 1'b1 || vs_p !== 1'b0) $display("FAIL vs_1600: vs=%b vs_p=%b want 1/0", vs, vs_p); else pass_cnt++;
         end
         tick();
      end
      total_cnt++; if (hs_low != 96) $display("FAIL hs_low_count: got %0d want 96", hs_low); else pass_cnt++;
      total_cnt++; if (pol_err != 0) $display("FAIL pol_mirror: got %0d mismatching clocks want 0", pol_err); else pass_cnt++;
   endtask

   task automatic test_small_frame();
      int vs_low = 0, hs_low = 0, en_high = 0, ticks = 0, tick_err = 0, blank_err = 0;
      int rel;
      force_val = 16'hFFFF;
      run_to(1700);
      for (int i = 0; i < 340; i++) begin
         rel = t - 1700;
         if (vs_s === 1'b0) vs_low++;
         if (hs_s === 1'b0) hs_low++;
         if (en_s === 1'b1) en_high++;
         if (ft_s === 1'b1) ticks++;
         if (ft_s !== ((rel % 170) == 169)) tick_err++;
         if (rgb_s !== (en_s ? 16'hFFFF : 16'h0000)) blank_err++;
         if (rel == 91) begin
            total_cnt++; if (en_s !== 1'b0 || xpos_s !== 11'd0) $display("FAIL s_req_first: en=%b x=%0d want 0,0", en_s, xpos_s); else pass_cnt++;
         end
         if (rel == 92) begin
            total_cnt++; if (en_s !== 1'b1 || xpos_s !== 11'd1) $display("FAIL s_act_first: en=%b x=%0d want 1,1", en_s, xpos_s); else pass_cnt++;
         end
         if (rel == 98) begin
            total_cnt++; if (xpos_s !== 11'd7 || ypos_s !== 11'd0) $display("FAIL s_req_last: x=%0d y=%0d want 7,0", xpos_s, ypos_s); else pass_cnt++;
         end
         if (rel == 115) begin
            total_cnt++; if (ypos_s !== 11'd1) $display("FAIL s_ypos: got %0d want 1", ypos_s); else pass_cnt++;
         end
         tick();
      end
      total_cnt++; if (vs_low != 68) $display("FAIL s_vs_low: got %0d want 68", vs_low); else pass_cnt++;
      total_cnt++; if (hs_low != 80) $display("FAIL s_hs_low: got %0d want 80", hs_low); else pass_cnt++;
      total_cnt++; if (en_high != 64) $display("FAIL s_en_high: got %0d want 64", en_high); else pass_cnt++;
      total_cnt++; if (ticks != 2 || tick_err != 0) $display("FAIL s_frame_tick: count %0d misplaced %0d want 2,0", ticks, tick_err); else pass_cnt++;
      total_cnt++; if (blank_err != 0) $display("FAIL s_blank: got %0d bad clocks want 0", blank_err); else pass_cnt++;
   endtask

   task automatic test_vblank();
      int err = 0;
      force_val = 16'hFFFF;
      while (t < T0) begin
         if (en !== 1'b0 || rgb !== 16'h0000 || xpos !== 11'd0 || ypos !== 11'd0 || vs !== 1'b1) err++;
         tick();
      end
      total_cnt++; if (err != 0) $display("FAIL vblank: got %0d bad clocks want 0", err); else pass_cnt++;
   endtask

   task automatic test_active_line();
      use_gen = 1'b1;
      run_to(T0 + 143);
      total_cnt++; if (xpos !== 11'd0 || ypos !== 11'd0 || en !== 1'b0 || rgb !== 16'd0) $display("FAIL line_143: x=%0d y=%0d en=%b rgb=%0d want 0,0,0,0", xpos, ypos, en, rgb); else pass_cnt++;
      run_to(T0 + 144);
      total_cnt++; if (en !== 1'b1 || rgb !== 16'd0 || xpos !== 11'd1) $display("FAIL line_144: en=%b rgb=%0d x=%0d want 1,0,1", en, rgb, xpos); else pass_cnt++;
      run_to(T0 + 145);
      total_cnt++; if (rgb !== 16'd1) $display("FAIL line_145: rgb=%0d want 1", rgb); else pass_cnt++;
      run_to(T0 + 782);
      total_cnt++; if (xpos !== 11'd639 || rgb !== 16'd638) $display("FAIL line_782: x=%0d rgb=%0d want 639,638", xpos, rgb); else pass_cnt++;
      run_to(T0 + 783);
      total_cnt++; if (en !== 1'b1 || rgb !== 16'd639 || xpos !== 11'd0) $display("FAIL line_783: en=%b rgb=%0d x=%0d want 1,639,0", en, rgb, xpos); else pass_cnt++;
      run_to(T0 + 784);
      total_cnt++; if (en !== 1'b0 || rgb !== 16'd0) $display("FAIL line_784: en=%b rgb=%0d want 0,0", en, rgb); else pass_cnt++;
   endtask

   task automatic test_hblank();
      int en_high = 0, en_err = 0, blank_err = 0;
      int h;
      use_gen = 1'b0; force_val = 16'hFFFF;
      run_to(T0 + 800);
      for (int i = 0; i < 800; i++) begin
         h = t - (T0 + 800);
         if (en === 1'b1) en_high++;
         if (en !== (h >= 144 && h < 784)) en_err++;
         if (rgb !== (en ? 16'hFFFF : 16'h0000)) blank_err++;
         if (h == 300) begin
            total_cnt++; if (xpos !== 11'd157 || ypos !== 11'd1) $display("FAIL line36_pos: x=%0d y=%0d want 157,1", xpos, ypos); else pass_cnt++;
         end
         tick();
      end
      total_cnt++; if (en_high != 640 || en_err != 0) $display("FAIL line36_en: high %0d misplaced %0d want 640,0", en_high, en_err); else pass_cnt++;
      total_cnt++; if (blank_err != 0) $display("FAIL line36_blank: got %0d bad clocks want 0", blank_err); else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      int ticks = 0, tick_err = 0;
      run_to(T0 + 2 * 800 + 400);
      rstn = 1'b0;
      tick();
      total_cnt++; if ({hs, vs, en} !== 3'b000 || xpos !== 11'd0 || ypos !== 11'd0) $display("FAIL midrst_state: hs,vs,en=%b x=%0d y=%0d want 000,0,0", {hs, vs, en}, xpos, ypos); else pass_cnt++;
      total_cnt++; if ({hs_p, vs_p} !== 2'b11 || ft_s !== 1'b0) $display("FAIL midrst_aux: pol=%b tick_s=%b want 11,0", {hs_p, vs_p}, ft_s); else pass_cnt++;
      rstn = 1'b1;
      t = 0;
      for (int i = 0; i < 340; i++) begin
         if (ft_s === 1'b1) ticks++;
         if (ft_s !== ((t % 170) == 169)) tick_err++;
         if (t == 96) begin
            total_cnt++; if (hs !== 1'b1) $display("FAIL midrst_hs96: got %b want 1", hs); else pass_cnt++;
         end
         tick();
      end
      total_cnt++; if (ticks != 2 || tick_err != 0) $display("FAIL midrst_tick: count %0d misplaced %0d want 2,0", ticks, tick_err); else pass_cnt++;
      total_cnt++; if (ft_hits != 0) $display("FAIL full_tick_early: got %0d pulses want 0", ft_hits); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_sync();
      test_small_frame();
      test_vblank();
      test_active_line();
      test_hblank();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/vga_timing_driver.md
Name: vga_timing_driver

Overview:
- Upstream stage of the start-screen and game pixel generators. Produces VGA sync, blanking and pixel coordinates for 640x480@60 Hz.
- Pixel generators register their colour one cycle after seeing a coordinate. This block therefore issues coordinates one clock early and drives the returned 16-bit RGB565 pixel onto the VGA bus during the active window.
- Also emits a once-per-frame tick that the game logic uses as its update strobe.

Parameters:
H_SYNC, 96, horizontal sync pulse width in pixel clocks
H_BACK, 48, horizontal back porch
H_DISP, 640, horizontal active pixels
H_FRONT, 16, horizontal front porch
V_SYNC, 2, vertical sync width in lines
V_BACK, 33, vertical back porch
V_DISP, 480, vertical active lines
V_FRONT, 10, vertical front porch
SYNC_POL, 0, active level of vga_hs/vga_vs (0 = active-low)

Ports:
clk  input  1  VGA pixel clock (25.2 MHz nominal)
rstn  input  1  synchronous active-low reset, sampled on rising clk
pixel_data  input  16  RGB565 colour from the downstream pixel generator; corresponds to coordinates issued the previous cycle
pixel_xpos  output  11  column of the pixel requested this cycle; 0 outside the request window
pixel_ypos  output  11  row of the pixel requested this cycle; 0 outside the request window
vga_hs  output  1  horizontal sync
vga_vs  output  1  vertical sync
vga_en  output  1  high while the active display pixel is on the bus
vga_rgb  output  16  pixel_data when vga_en=1, else 16'h0000
frame_tick  output  1  one-cycle pulse on the last clock of each frame

Behaviour:
- Derived constants:
  - H_TOTAL = sum of the H_* parameters = 800; V_TOTAL = sum of the V_* parameters = 525.
  - H_START = H_SYNC+H_BACK = 144; V_START = V_SYNC+V_BACK = 35.
- Counters:
  - cnt_h and cnt_v are 11-bit registers.
  - cnt_h increments every clock and wraps from H_TOTAL-1 to 0.
  - cnt_v increments only on the clock where cnt_h wraps. It wraps from V_TOTAL-1 to 0 on the clock where both counters wrap.
- Reset: while rstn=0 at a rising edge, both counters load 0. No other state exists.
- All outputs are combinational decodes of the counter registers (plus pass-through of pixel_data). Values during and immediately after reset follow from cnt_h=cnt_v=0:
  - vga_hs=vga_vs=SYNC_POL (sync asserted)
  - vga_en=0, vga_rgb=0
  - pixel_xpos=pixel_ypos=0
  - frame_tick=0
- Sync:
  - vga_hs = SYNC_POL when cnt_h < H_SYNC, else ~SYNC_POL.
  - vga_vs = SYNC_POL when cnt_v < V_SYNC, else ~SYNC_POL.
- Active window: vga_en=1 iff H_START <= cnt_h < H_START+H_DISP and V_START <= cnt_v < V_START+V_DISP.
- Request window (one clock early): data_req=1 iff H_START-1 <= cnt_h < H_START+H_DISP-1 and cnt_v is in the active range.
  - When data_req=1: pixel_xpos = cnt_h-(H_START-1), pixel_ypos = cnt_v-V_START. When data_req=0, both are 0.
  - Consequence: xpos=0 is issued at cnt_h=143 and the corresponding pixel_data is displayed at cnt_h=144 (1-cycle latency).
  - xpos=639 is issued at cnt_h=782 and displayed at cnt_h=783.
- vga_rgb = vga_en ? pixel_data : 16'h0000. Blanking is always black regardless of pixel_data.
- frame_tick=1 iff cnt_h=H_TOTAL-1 and cnt_v=V_TOTAL-1. Exactly one pulse per 420000 clocks.
- Reset mid-line or mid-frame: counters restart at 0 on the next edge. A partial frame is abandoned and no frame_tick is produced for it.
- Coordinate arithmetic is unsigned 11-bit. Subtractions are evaluated only inside the window, so no underflow is visible.

Decomposition:
- Shared package (vga_timing_pkg): the 640x480 timing constants, derived totals/starts, and RGB565 black constant. Other display stages use the same constants.
- One natural sub-module, vga_axis_counter, parameterised by SYNC, BACK, DISP, FRONT. Instantiated twice (horizontal, vertical-with-enable). Provides count, wrap, sync, active and request-window flags.

Test Plan:
1. Reset held 3 cycles, then released -> cnt 0 state: vga_hs=0, vga_vs=0, vga_en=0, vga_rgb=0, xpos=ypos=0. Falling edge of hs at clock 0, rising edge after 96 clocks. Line period 800 clocks.
2. pixel_data driven as {5'd0, xpos_prev[10:0]} model on line V_START -> xpos=0 at cnt_h=143, vga_en rises at cnt_h=144 with vga_rgb=0. Last active pixel vga_rgb=639 at cnt_h=783, vga_en=0 at cnt_h=784.
3. Run a full frame -> vga_vs low for exactly 1600 clocks (2 lines). vga_en high for 480x640 clocks total. frame_tick pulses once, at clock 419999; next pulse at 839999.
4. pixel_data forced to 16'hFFFF -> vga_rgb=16'h0000 at every clock where vga_en=0 (porches, sync, vertical blank).
5. Assert rstn=0 for 1 cycle at cnt_h=400, cnt_v=200 -> next cycle counters 0, sync asserted. No frame_tick until 420000 clocks after reset release.
6. SYNC_POL=1 build -> vga_hs high for cnt_h 0..95, low otherwise. vga_vs high for lines 0..1. All other timing unchanged from scenario 1.
